// File: rtl/fifo_burst_reader.sv
// Read-side master for the team FIFO: pops exactly `length` words per burst and
// presents them on a valid/ready stream through a 2-entry skid buffer.
module fifo_burst_reader #(
  parameter int unsigned SIZE  = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  input  logic             fifo_empty,
  input  logic [SIZE-1:0]  fifo_data,
  output logic             fifo_read_update,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_data,
  output logic             out_last
);

  if (DEPTH == 0) begin : g_depth_chk
    $error("fifo_burst_reader: DEPTH must be nonzero");
  end

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic                       done_nxt;
  logic [LEN_W-1:0]           remaining;
  logic [1:0][SIZE-1:0]       buf_data;
  logic [1:0]                 buf_last;
  logic                       wr_ptr;
  logic                       rd_ptr;
  logic [1:0]                 occ;
  logic                       pop_c;
  logic                       xfer_c;
  logic                       load_c;

  // Pop only while words are still owed and the buffer has a free slot.
  assign pop_c  = (state == READ) && !fifo_empty && (remaining != '0) && (occ != 2'd2);
  assign xfer_c = out_valid && out_ready;
  assign load_c = (state == IDLE) && start && (length != '0);

  assign fifo_read_update = pop_c;
  assign busy             = (state != IDLE);
  assign out_valid        = (occ != 2'd0);
  assign out_data         = buf_data[rd_ptr];
  assign out_last         = buf_last[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (length != '0) state_nxt = READ;
          else              done_nxt  = 1'b1;
        end
      end
      READ: begin
        if (pop_c && (remaining == LEN_W'(1))) state_nxt = DRAIN;
      end
      DRAIN: begin
        // The last-tagged word can only be at the head once popping has finished.
        if (xfer_c && out_last) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst counter and output buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining <= '0;
      buf_data  <= '0;
      buf_last  <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occ       <= 2'd0;
    end else begin
      if (load_c)     remaining <= length;
      else if (pop_c) remaining <= remaining - LEN_W'(1);

      if (pop_c) begin
        buf_data[wr_ptr] <= fifo_data;
        buf_last[wr_ptr] <= (remaining == LEN_W'(1));
        wr_ptr           <= ~wr_ptr;
      end

      if (xfer_c) rd_ptr <= ~rd_ptr;

      unique case ({pop_c, xfer_c})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a queue-based FIFO, a word-level
// scoreboard model checked every cycle, and literal expectations per scenario.
module tb_fifo_burst_reader;

  localparam int unsigned SIZE  = 16;
  localparam int unsigned LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] length = '0;
  logic             busy;
  logic             done;
  logic             fifo_empty = 1'b1;
  logic [SIZE-1:0]  fifo_data = '0;
  logic             fifo_read_update;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [SIZE-1:0]  out_data;
  logic             out_last;
  logic             wr_en = 1'b0;
  logic [SIZE-1:0]  wr_data = '0;

  fifo_burst_reader #(.SIZE(SIZE), .DEPTH(4), .LEN_W(LEN_W)) dut (
    .clk              (clk),
    .reset            (rst_n),
    .start            (start),
    .length           (length),
    .busy             (busy),
    .done             (done),
    .fifo_empty       (fifo_empty),
    .fifo_data        (fifo_data),
    .fifo_read_update (fifo_read_update),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_last         (out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SIZE-1:0] word;
    logic            is_last;
  } ent_t;

  logic [SIZE-1:0] fifo_q[$];
  ent_t            exp_q[$];
  ent_t            xfer_log[$];
  int              pop_cyc[$];

  bit m_active = 1'b0;
  int m_left   = 0;
  bit m_done   = 1'b0;
  int cycle    = 0;
  int pop_cnt  = 0;
  int done_cnt = 0;
  int checks   = 0;
  int errors   = 0;

  // Words in flight = popped but not yet accepted downstream; at most two.
  function automatic bit model_pop();
    return m_active && (m_left > 0) && (fifo_q.size() > 0) && (exp_q.size() < 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Model, FIFO and observation counters, all advanced on the clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_left   = 0;
      m_done   = 1'b0;
      exp_q.delete();
    end else begin
      bit   mp, xf, lx, was_active;
      ent_t e;
      mp         = model_pop();
      xf         = (exp_q.size() > 0) && out_ready;
      lx         = xf && exp_q[0].is_last;
      was_active = m_active;
      cycle++;
      if (fifo_read_update) begin
        pop_cnt++;
        pop_cyc.push_back(cycle);
      end
      if (out_valid && out_ready) begin
        e.word    = out_data;
        e.is_last = out_last;
        xfer_log.push_back(e);
      end
      if (done) done_cnt++;
      m_done = lx || (!was_active && start && (length == '0));
      if (xf) void'(exp_q.pop_front());
      if (mp) begin
        e.word    = fifo_q[0];
        e.is_last = (m_left == 1);
        exp_q.push_back(e);
        m_left--;
      end
      if (lx) m_active = 1'b0;
      else if (!was_active && start && (length != '0)) begin
        m_active = 1'b1;
        m_left   = int'(length);
      end
      if (fifo_read_update && (fifo_q.size() > 0)) void'(fifo_q.pop_front());
      if (wr_en) fifo_q.push_back(wr_data);
      fifo_empty <= (fifo_q.size() == 0);
      fifo_data  <= (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_active));
    check("done", 32'(done), 32'(m_done));
    check("fifo_read_update", 32'(fifo_read_update), 32'(model_pop()));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check("out_data", 32'(out_data), 32'(exp_q[0].word));
      check("out_last", 32'(out_last), 32'(exp_q[0].is_last));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [SIZE-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic burst(input int len);
    start  = 1'b1;
    length = LEN_W'(len);
    step();
    start  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int n = 0; n < budget && !done; n++) step();
    check(name, 32'(done), 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_pop"}, 32'(fifo_read_update), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int p0, l0, c0, d0;

    // Reset values
    #2;
    check_zero_outputs("reset");
    step();
    step();
    rst_n = 1'b1;

    // Basic burst A1..A4
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(SIZE'(16'hA1 + i));
    p0 = pop_cnt; l0 = xfer_log.size(); c0 = pop_cyc.size(); d0 = done_cnt;
    burst(4);
    check("basic_busy_after_start", 32'(busy), 32'd1);
    wait_done("basic_done", 20);
    step();
    check("basic_done_one_cycle", 32'(done), 32'd0);
    check("basic_pops", 32'(pop_cnt - p0), 32'd4);
    check("basic_xfers", 32'(xfer_log.size() - l0), 32'd4);
    check("basic_done_count", 32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("basic_word", 32'(xfer_log[l0 + i].word), 32'h0A1 + 32'(i));
      check("basic_last", 32'(xfer_log[l0 + i].is_last), (i == 3) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 3; i++)
      check("basic_pop_spacing", 32'(pop_cyc[c0 + i + 1] - pop_cyc[c0 + i]), 32'd1);

    // Backpressure B1..B3
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(SIZE'(16'hB1 + i));
    p0 = pop_cnt; l0 = xfer_log.size();
    burst(3);
    repeat (5) step();
    check("bp_pops_held", 32'(pop_cnt - p0), 32'd2);
    check("bp_valid_held", 32'(out_valid), 32'd1);
    check("bp_data_held", 32'(out_data), 32'h0B1);
    out_ready = 1'b1;
    wait_done("bp_done", 20);
    step();
    check("bp_pops", 32'(pop_cnt - p0), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("bp_word", 32'(xfer_log[l0 + i].word), 32'h0B1 + 32'(i));
      check("bp_last", 32'(xfer_log[l0 + i].is_last), (i == 2) ? 32'd1 : 32'd0);
    end

    // Underflow stall: words trickle in every 4 cycles
    p0 = pop_cnt; l0 = xfer_log.size();
    burst(2);
    repeat (3) step();
    check("stall_no_pop_empty", 32'(pop_cnt - p0), 32'd0);
    push(16'h00C1);
    repeat (3) step();
    push(16'h00C2);
    wait_done("stall_done", 20);
    step();
    check("stall_pops", 32'(pop_cnt - p0), 32'd2);
    check("stall_word0", 32'(xfer_log[l0].word), 32'h0C1);
    check("stall_word1", 32'(xfer_log[l0 + 1].word), 32'h0C2);
    check("stall_last1", 32'(xfer_log[l0 + 1].is_last), 32'd1);

    // Zero length and start while busy
    p0 = pop_cnt;
    burst(0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    step();
    check("zero_done_pulse", 32'(done), 32'd0);
    check("zero_no_pop", 32'(pop_cnt - p0), 32'd0);
    for (int i = 0; i < 3; i++) push(SIZE'(16'hD1 + i));
    l0 = xfer_log.size();
    burst(2);
    start = 1'b1; length = LEN_W'(3);
    step();
    start = 1'b0;
    wait_done("busy_start_done", 20);
    step();
    check("busy_start_pops", 32'(pop_cnt - p0), 32'd2);
    check("busy_start_xfers", 32'(xfer_log.size() - l0), 32'd2);
    burst(1);
    wait_done("flush_d3_done", 20);
    step();
    check("flush_d3_word", 32'(xfer_log[xfer_log.size() - 1].word), 32'h0D3);

    // Reset mid-burst after two pops
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(SIZE'(16'hE1 + i));
    p0 = pop_cnt;
    burst(5);
    for (int n = 0; n < 10 && (pop_cnt - p0) < 2; n++) step();
    check("pre_reset_pops", 32'(pop_cnt - p0), 32'd2);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    step();
    rst_n = 1'b1;
    check("post_reset_pops", 32'(pop_cnt - p0), 32'd2);
    out_ready = 1'b1;
    l0 = xfer_log.size();
    burst(1);
    wait_done("post_reset_done", 20);
    step();
    check("post_reset_xfers", 32'(xfer_log.size() - l0), 32'd1);
    check("post_reset_word", 32'(xfer_log[l0].word), 32'h0E3);
    check("post_reset_last", 32'(xfer_log[l0].is_last), 32'd1);

    // Back-to-back bursts: restart in the done-pulse cycle
    l0 = xfer_log.size();
    burst(1);
    wait_done("b2b_first_done", 20);
    start = 1'b1; length = LEN_W'(1);
    step();
    start = 1'b0;
    check("b2b_no_idle", 32'(busy), 32'd1);
    wait_done("b2b_second_done", 20);
    step();
    check("b2b_xfers", 32'(xfer_log.size() - l0), 32'd2);
    check("b2b_word0", 32'(xfer_log[l0].word), 32'h0E4);
    check("b2b_last0", 32'(xfer_log[l0].is_last), 32'd1);
    check("b2b_word1", 32'(xfer_log[l0 + 1].word), 32'h0E5);
    check("b2b_last1", 32'(xfer_log[l0 + 1].is_last), 32'd1);

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- SIZE, 16, data word width in bits.
- DEPTH, 4, FIFO address width; informational only.
- LEN_W, 8, burst length field width.

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  burst request strobe.
- length  in  LEN_W  words to read; sampled with start.
- busy  out  1  burst in progress.
- done  out  1  one-cycle burst-complete pulse.
- fifo_empty  in  1  empty flag from FIFO.
- fifo_data  in  SIZE  FIFO head word; valid combinationally whenever fifo_empty=0.
- fifo_read_update  out  1  pop strobe to FIFO read_update.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_data  out  SIZE  output word.
- out_last  out  1  marks final word of burst.

Function
REQ-003 The block SHALL act as the read-side master of the team FIFO, converting pops into a valid/ready stream of exactly `length` words per burst.
REQ-004 The FSM SHALL have exactly the states IDLE, READ and DRAIN; busy SHALL be 1 in READ and DRAIN.
REQ-005 In IDLE, start=1 with length>0 SHALL load remaining<=length and move to READ on the next edge.
REQ-006 In IDLE, start=1 with length=0 SHALL pulse done on the next cycle, issue no pop and stay in IDLE.
REQ-007 start SHALL be ignored while busy=1.
REQ-008 The block SHALL hold a 2-entry output buffer with an occupancy count of 0..2.
REQ-009 fifo_read_update SHALL be combinational: 1 iff state=READ, fifo_empty=0, remaining>0 and occupancy<2.
REQ-010 On a pop, fifo_data SHALL be written into the buffer tail on the same edge and remaining SHALL decrement by 1.
REQ-011 The buffer entry written when remaining=1 SHALL be tagged last.
REQ-012 Pop-to-out_valid latency SHALL be 1 cycle.
REQ-013 out_valid SHALL equal (occupancy>0); out_data and out_last SHALL reflect the buffer head.
REQ-014 A transfer SHALL occur iff out_valid=1 and out_ready=1, and SHALL remove the head on that edge.
REQ-015 A simultaneous pop and transfer SHALL leave occupancy unchanged, sustaining 1 word/cycle.
REQ-016 out_data and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-017 When remaining reaches 0, READ SHALL go to DRAIN.
REQ-018 The transfer of the last-tagged word SHALL move the FSM to IDLE and pulse done=1 for exactly the following cycle.
REQ-019 fifo_empty=1 in READ SHALL stall popping with no error, no timeout and no state change.
REQ-020 fifo_read_update SHALL never assert while fifo_empty=1 or while in IDLE or DRAIN.
REQ-021 remaining SHALL never underflow; the block SHALL issue no more than `length` pops per burst.
REQ-022 A new start SHALL be accepted in the done-pulse cycle, because the FSM is already in IDLE.

Reset
REQ-023 reset=0 SHALL asynchronously force: state=IDLE, remaining=0, occupancy=0, busy=0, done=0, out_valid=0, out_last=0, out_data=0, fifo_read_update=0.
REQ-024 Reset mid-burst SHALL discard buffered words; words already popped are lost and SHALL NOT be re-requested.
REQ-025 Reset release SHALL be synchronous to clk; the first start SHALL be honoured on the first edge after release.

Verification
REQ-026 Basic burst: FIFO preloaded with 0xA1..0xA4, start with length=4, out_ready=1 -> 4 pops on consecutive cycles; out_data 0xA1..0xA4 on consecutive cycles; out_last only with 0xA4; one done pulse.
REQ-027 Backpressure: length=3, out_ready=0 for 5 cycles -> exactly 2 pops, then out_valid held with out_data stable; after out_ready=1, remaining word popped, order preserved, done after third transfer.
REQ-028 Underflow stall: FIFO empty, length=2, one word written every 4 cycles -> pops only when fifo_empty=0, never while empty; 2 transfers, then done.
REQ-029 Zero length and busy start: start with length=0 -> done next cycle, no pop; start during an active burst -> ignored, pop count matches original length.
REQ-030 Reset mid-burst: reset=0 after 2 of 5 words -> all outputs 0 immediately; new burst with length=1 -> next FIFO word (3rd written) delivered with out_last=1.
REQ-031 Back-to-back: start asserted in the done-pulse cycle -> second burst begins with no idle cycle; out_last asserted once per burst.
